// File: rtl/switch_allocator_rr_if.sv
// Handshake bundle between the input buffers, the switch allocator and the crossbar.
// The allocator takes the slave modport; the buffers/crossbar side takes master.
interface switch_allocator_rr_if #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned DPORT_W   = 3
);
    logic [NUM_PORTS-1:0]         in_req;
    logic [NUM_PORTS*DPORT_W-1:0] in_dport;
    logic [NUM_PORTS-1:0]         in_tail;
    logic [NUM_PORTS-1:0]         out_ready;
    logic [NUM_PORTS-1:0]         in_grant;
    logic [NUM_PORTS-1:0]         out_valid;
    logic [NUM_PORTS*DPORT_W-1:0] out_sel;

    modport master (
        output in_req, in_dport, in_tail, out_ready,
        input  in_grant, out_valid, out_sel
    );

    modport slave (
        input  in_req, in_dport, in_tail, out_ready,
        output in_grant, out_valid, out_sel
    );
endinterface

// File: rtl/switch_allocator_rr.sv
// Separable switch allocator: one round-robin arbiter with a packet-level lock per output.
// Optional macro SA_CREDIT_CHECK_EN gates arbitration and grants with out_ready.
module switch_allocator_rr #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned DPORT_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_allocator_rr_if.slave sa
);
    localparam int unsigned CAND_W = 1 << DPORT_W;
    localparam int unsigned IDX_W  = DPORT_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Request/tail vectors padded so an owner index of DPORT_W bits always selects in range
    logic [CAND_W-1:0]    req_pad;
    logic [CAND_W-1:0]    tail_pad;
    logic [NUM_PORTS-1:0] grant_by_out [NUM_PORTS];
    logic                 valid_by_out [NUM_PORTS];
    logic [DPORT_W-1:0]   sel_by_out   [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant_c;
    logic [NUM_PORTS-1:0] valid_c;
    logic [NUM_PORTS*DPORT_W-1:0] sel_c;

    assign req_pad  = CAND_W'(sa.in_req);
    assign tail_pad = CAND_W'(sa.in_tail);

`ifndef SA_CREDIT_CHECK_EN
    logic unused_ready;
    assign unused_ready = ^sa.out_ready;
`endif

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        state_e             state_q;
        state_e             state_d;
        logic [DPORT_W-1:0] owner_q;
        logic [DPORT_W-1:0] owner_d;
        logic [DPORT_W-1:0] ptr_q;
        logic [DPORT_W-1:0] ptr_d;
        logic [DPORT_W-1:0] winner;
        logic [IDX_W-1:0]   idx;
        logic [CAND_W-1:0]  cand;
        logic               found;
        logic               ready;
        logic               owner_req;
        logic               owner_tail;
        logic               grant;

`ifdef SA_CREDIT_CHECK_EN
        assign ready = sa.out_ready[o];
`else
        assign ready = 1'b1;
`endif

        // Inputs whose head flit targets this output; out-of-range dports never match
        always_comb begin
            cand = '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cand[i] = sa.in_req[i] &&
                          (sa.in_dport[i*DPORT_W +: DPORT_W] == DPORT_W'(o));
            end
        end

        // Round-robin scan starting at ptr, wrapping modulo NUM_PORTS
        always_comb begin
            found  = 1'b0;
            winner = '0;
            idx    = '0;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                idx = IDX_W'(ptr_q) + IDX_W'(k);
                if (idx >= IDX_W'(NUM_PORTS)) begin
                    idx = idx - IDX_W'(NUM_PORTS);
                end
                if (!found && cand[idx[DPORT_W-1:0]]) begin
                    found  = 1'b1;
                    winner = idx[DPORT_W-1:0];
                end
            end
        end

        assign owner_req  = req_pad[owner_q];
        assign owner_tail = tail_pad[owner_q];
        assign grant      = (state_q == ST_LOCKED) && owner_req && ready;

        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            case (state_q)
                ST_IDLE: begin
                    if (found && ready) begin
                        state_d = ST_LOCKED;
                        owner_d = winner;
                        ptr_d   = (winner == DPORT_W'(NUM_PORTS - 1)) ? '0
                                                                      : winner + DPORT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Abort or tail transfer frees the output; a stalled tail keeps the lock
                    if (!owner_req || (grant && owner_tail)) begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
                owner_q <= '0;
                ptr_q   <= '0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                ptr_q   <= ptr_d;
            end
        end

        assign grant_by_out[o] = grant ? (NUM_PORTS'(1) << owner_q) : '0;
        assign valid_by_out[o] = (state_q == ST_LOCKED);
        assign sel_by_out[o]   = owner_q;
    end

    // Each input has a single dport, so at most one output contributes to its grant
    always_comb begin
        grant_c = '0;
        valid_c = '0;
        sel_c   = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            grant_c                        = grant_c | grant_by_out[o];
            valid_c[o]                     = valid_by_out[o];
            sel_c[o*DPORT_W +: DPORT_W]    = sel_by_out[o];
        end
    end

    assign sa.in_grant  = grant_c;
    assign sa.out_valid = valid_c;
    assign sa.out_sel   = sel_c;

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Self-checking bench for switch_allocator_rr: directed scenarios plus randomized
// packet traffic, all compared against a behavioural per-output lock/round-robin model.
module tb_switch_allocator_rr;
    localparam int N = 5;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_allocator_rr_if #(.NUM_PORTS(N), .DPORT_W(W)) sa_bus ();

    switch_allocator_rr #(.NUM_PORTS(N), .DPORT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .sa  (sa_bus)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus state, as the input buffers present it
    bit req  [N];
    int dport[N];
    bit tail [N];
    bit rdy  [N];

    // Reference model: per output a lock flag, owner and round-robin start point
    bit m_locked[N];
    int m_owner [N];
    int m_ptr   [N];

    logic [N-1:0]   exp_grant;
    logic [N-1:0]   exp_valid;
    logic [N*W-1:0] exp_sel;

    function automatic bit ready_eff(int o);
        bit r;
        r = rdy[o];
`ifndef SA_CREDIT_CHECK_EN
        r = 1'b1;
`endif
        return r;
    endfunction

    function automatic void model_reset();
        for (int o = 0; o < N; o++) begin
            m_locked[o] = 1'b0;
            m_owner[o]  = 0;
            m_ptr[o]    = 0;
        end
    endfunction

    function automatic void model_expect();
        exp_grant = '0;
        exp_valid = '0;
        exp_sel   = '0;
        for (int o = 0; o < N; o++) begin
            if (m_locked[o]) begin
                exp_valid[o]        = 1'b1;
                exp_sel[o*W +: W]   = W'(m_owner[o]);
                if (req[m_owner[o]] && ready_eff(o)) exp_grant[m_owner[o]] = 1'b1;
            end
        end
    endfunction

    function automatic void model_step();
        int  ow;
        int  i;
        bit  found;
        for (int o = 0; o < N; o++) begin
            if (m_locked[o]) begin
                ow = m_owner[o];
                if (!req[ow] || (ready_eff(o) && tail[ow])) begin
                    m_locked[o] = 1'b0;
                    m_owner[o]  = 0;
                end
            end else if (ready_eff(o)) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr[o] + k) % N;
                    if (!found && req[i] && dport[i] == o) begin
                        found       = 1'b1;
                        m_locked[o] = 1'b1;
                        m_owner[o]  = i;
                        m_ptr[o]    = (i + 1) % N;
                    end
                end
            end
        end
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            req[i]   = 1'b0;
            dport[i] = 0;
            tail[i]  = 1'b0;
            rdy[i]   = 1'b1;
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            sa_bus.in_req[i]             = req[i];
            sa_bus.in_dport[i*W +: W]    = W'(dport[i]);
            sa_bus.in_tail[i]            = tail[i];
            sa_bus.out_ready[i]          = rdy[i];
        end
    endtask

    // Drive on the falling edge, sample 1 time unit later
    task automatic apply();
        @(negedge clk);
        drive_bus();
        #1;
        model_expect();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic pulse_reset();
        clear_inputs();
        drive_bus();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        drive_bus();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        total++;
        if (sa_bus.in_grant !== '0) begin
            bad++; $display("FAIL reset_grant got=%b want=%b", sa_bus.in_grant, 5'b0);
        end
        total++;
        if (sa_bus.out_valid !== '0) begin
            bad++; $display("FAIL reset_valid got=%b want=%b", sa_bus.out_valid, 5'b0);
        end
        total++;
        if (sa_bus.out_sel !== '0) begin
            bad++; $display("FAIL reset_sel got=%h want=0", sa_bus.out_sel);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_flit();
        clear_inputs();
        req[0] = 1'b1; dport[0] = 2; tail[0] = 1'b1;
        apply();
        total++;
        if (sa_bus.in_grant !== 5'b00000) begin
            bad++; $display("FAIL single_c1_grant got=%b want=%b", sa_bus.in_grant, 5'b00000);
        end
        tick();
        apply();
        total++;
        if (sa_bus.in_grant !== 5'b00001 || sa_bus.in_grant !== exp_grant) begin
            bad++; $display("FAIL single_c2_grant got=%b want=%b", sa_bus.in_grant, 5'b00001);
        end
        total++;
        if (sa_bus.out_valid !== 5'b00100 || sa_bus.out_sel[2*W +: W] !== 3'd0) begin
            bad++; $display("FAIL single_c2_out got valid=%b sel2=%0d want valid=00100 sel2=0",
                            sa_bus.out_valid, sa_bus.out_sel[2*W +: W]);
        end
        tick();
        req[0] = 1'b0;
        apply();
        total++;
        if (sa_bus.out_valid !== 5'b00000 || sa_bus.in_grant !== 5'b00000) begin
            bad++; $display("FAIL single_c3_release got valid=%b grant=%b want 00000/00000",
                            sa_bus.out_valid, sa_bus.in_grant);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int got[$];
        int when[$];
        int exp_order[6] = '{1, 3, 4, 1, 3, 4};
        pulse_reset();
        clear_inputs();
        foreach (exp_order[k]) begin
            if (k < 3) begin
                req[exp_order[k]] = 1'b1; dport[exp_order[k]] = 0; tail[exp_order[k]] = 1'b1;
            end
        end
        for (int c = 0; c < 12; c++) begin
            apply();
            total++;
            if (sa_bus.in_grant !== exp_grant || sa_bus.out_valid !== exp_valid) begin
                bad++; $display("FAIL rr_cycle c=%0d got grant=%b valid=%b want grant=%b valid=%b",
                                c, sa_bus.in_grant, sa_bus.out_valid, exp_grant, exp_valid);
            end
            for (int i = 0; i < N; i++) begin
                if (sa_bus.in_grant[i] === 1'b1) begin
                    got.push_back(i); when.push_back(c);
                end
            end
            tick();
        end
        total++;
        if (got.size() != 6) begin
            bad++; $display("FAIL rr_count got=%0d want=6", got.size());
        end
        for (int k = 0; k < 6; k++) begin
            if (k < got.size()) begin
                total++;
                if (got[k] != exp_order[k] || when[k] != 2 * k + 1) begin
                    bad++; $display("FAIL rr_order k=%0d got input=%0d cyc=%0d want input=%0d cyc=%0d",
                                    k, got[k], when[k], exp_order[k], 2 * k + 1);
                end
            end
        end
    endtask

    task automatic test_long_packet();
        int left2 = 4;
        int left0 = 1;
        int g2[$];
        int g0[$];
        pulse_reset();
        clear_inputs();
        for (int c = 0; c < 10; c++) begin
            req[2] = (left2 > 0); dport[2] = 4; tail[2] = (left2 == 1);
            req[0] = (c >= 1) && (left0 > 0); dport[0] = 4; tail[0] = 1'b1;
            apply();
            total++;
            if (sa_bus.in_grant !== exp_grant || sa_bus.out_sel !== exp_sel) begin
                bad++; $display("FAIL long_cycle c=%0d got grant=%b sel=%h want grant=%b sel=%h",
                                c, sa_bus.in_grant, sa_bus.out_sel, exp_grant, exp_sel);
            end
            if (sa_bus.in_grant[2] === 1'b1) g2.push_back(c);
            if (sa_bus.in_grant[0] === 1'b1) g0.push_back(c);
            if (exp_grant[2]) left2--;
            if (exp_grant[0]) left0--;
            tick();
        end
        total++;
        if (g2.size() != 4 || (g2.size() == 4 && (g2[0] != 1 || g2[3] != 4))) begin
            bad++; $display("FAIL long_hold got grants=%0d want 4 consecutive at cycles 1..4", g2.size());
        end
        total++;
        if (g0.size() != 1 || g2.size() == 0 || (g0.size() == 1 && g0[0] - g2[g2.size()-1] != 2)) begin
            bad++; $display("FAIL long_next got in0_grants=%0d first=%0d want 1 grant at cycle 6",
                            g0.size(), (g0.size() > 0) ? g0[0] : -1);
        end
    endtask

    task automatic test_all_ports();
        logic [N*W-1:0] want_sel;
        clear_inputs();
        apply(); tick();
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b1; dport[i] = (i + 1) % N; tail[i] = 1'b0;
        end
        apply(); tick();
        want_sel = '0;
        for (int o = 0; o < N; o++) want_sel[o*W +: W] = W'((o + N - 1) % N);
        apply();
        total++;
        if (sa_bus.in_grant !== 5'b11111 || sa_bus.out_valid !== 5'b11111) begin
            bad++; $display("FAIL all_grant got grant=%b valid=%b want 11111/11111",
                            sa_bus.in_grant, sa_bus.out_valid);
        end
        total++;
        if (sa_bus.out_sel !== want_sel || sa_bus.out_sel !== exp_sel) begin
            bad++; $display("FAIL all_sel got=%h want=%h", sa_bus.out_sel, want_sel);
        end
        tick();
        for (int i = 0; i < N; i++) tail[i] = 1'b1;
        apply(); tick();
        clear_inputs();
        apply();
        total++;
        if (sa_bus.out_valid !== 5'b00000) begin
            bad++; $display("FAIL all_release got valid=%b want=00000", sa_bus.out_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        clear_inputs();
        req[3] = 1'b1; dport[3] = 1; tail[3] = 1'b0;
        apply(); tick();
        apply();
        total++;
        if (sa_bus.in_grant !== 5'b01000 || sa_bus.out_valid !== 5'b00010) begin
            bad++; $display("FAIL midrst_pre got grant=%b valid=%b want 01000/00010",
                            sa_bus.in_grant, sa_bus.out_valid);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (sa_bus.in_grant !== 5'b00000 || sa_bus.out_valid !== 5'b00000) begin
            bad++; $display("FAIL midrst_async got grant=%b valid=%b want 00000/00000",
                            sa_bus.in_grant, sa_bus.out_valid);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        apply();
        total++;
        if (sa_bus.in_grant !== 5'b00000 || sa_bus.in_grant !== exp_grant) begin
            bad++; $display("FAIL midrst_idle got grant=%b want=00000", sa_bus.in_grant);
        end
        tick();
        apply();
        total++;
        if (sa_bus.in_grant !== 5'b01000 || sa_bus.out_sel[1*W +: W] !== 3'd3) begin
            bad++; $display("FAIL midrst_regrant got grant=%b sel1=%0d want 01000 sel1=3",
                            sa_bus.in_grant, sa_bus.out_sel[1*W +: W]);
        end
        tick();
        clear_inputs();
        apply(); tick();
    endtask

    task automatic test_credit();
        int left = 2;
        int g[$];
        int v[$];
        clear_inputs();
        for (int c = 0; c < 8; c++) begin
            req[3] = (left > 0); dport[3] = 3; tail[3] = (left == 1);
            rdy[3] = !(c >= 2 && c <= 4);
            apply();
            total++;
            if (sa_bus.in_grant !== exp_grant || sa_bus.out_valid !== exp_valid) begin
                bad++; $display("FAIL credit_cycle c=%0d got grant=%b valid=%b want grant=%b valid=%b",
                                c, sa_bus.in_grant, sa_bus.out_valid, exp_grant, exp_valid);
            end
            if (sa_bus.in_grant[3] === 1'b1) g.push_back(c);
            if (sa_bus.out_valid[3] === 1'b1) v.push_back(c);
            if (exp_grant[3]) left--;
            tick();
        end
`ifdef SA_CREDIT_CHECK_EN
        total++;
        if (g.size() != 2 || (g.size() == 2 && (g[0] != 1 || g[1] != 5))) begin
            bad++; $display("FAIL credit_grants got count=%0d want cycles 1,5", g.size());
        end
        total++;
        if (v.size() != 5 || (v.size() == 5 && (v[0] != 1 || v[4] != 5))) begin
            bad++; $display("FAIL credit_lock got valid_cycles=%0d want 5 (cycles 1..5)", v.size());
        end
`else
        total++;
        if (g.size() != 2 || (g.size() == 2 && (g[0] != 1 || g[1] != 2))) begin
            bad++; $display("FAIL noready_grants got count=%0d want cycles 1,2", g.size());
        end
        total++;
        if (v.size() != 2) begin
            bad++; $display("FAIL noready_lock got valid_cycles=%0d want 2", v.size());
        end
`endif
    endtask

    task automatic test_random();
        int rem  [N];
        int pdest[N];
        for (int i = 0; i < N; i++) begin rem[i] = 0; pdest[i] = 0; end
        clear_inputs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
                    rem[i]   = $urandom_range(1, 4);
                    pdest[i] = $urandom_range(0, 7);
                end else if (rem[i] > 0 && $urandom_range(0, 19) == 0) begin
                    rem[i] = 0;
                end else if (rem[i] > 0 && $urandom_range(0, 31) == 0) begin
                    pdest[i] = $urandom_range(0, 4);
                end
                req[i]   = (rem[i] > 0);
                dport[i] = pdest[i];
                tail[i]  = (rem[i] == 1);
                rdy[i]   = ($urandom_range(0, 3) != 0);
            end
            apply();
            total++;
            if (sa_bus.in_grant !== exp_grant) begin
                bad++; $display("FAIL rand_grant c=%0d got=%b want=%b", c, sa_bus.in_grant, exp_grant);
            end
            total++;
            if (sa_bus.out_valid !== exp_valid) begin
                bad++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, sa_bus.out_valid, exp_valid);
            end
            total++;
            if (sa_bus.out_sel !== exp_sel) begin
                bad++; $display("FAIL rand_sel c=%0d got=%h want=%h", c, sa_bus.out_sel, exp_sel);
            end
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i] && rem[i] > 0) rem[i]--;
            end
            tick();
        end
        clear_inputs();
        apply(); tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_flit();
        test_round_robin();
        test_long_packet();
        test_all_ports();
        test_reset_mid_packet();
        test_credit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
